// File: rtl/sga_snake_body.sv
// sga_snake_body: circular-buffer snake body with a head-first render stream.
// Optional define SGA_SELF_HIT_EN adds the sticky head-on-body detector (self_hit).
module sga_snake_body #(
  parameter int              POS_W    = 6,
  parameter int              MAX_LEN  = 16,
  parameter logic [POS_W-1:0] INIT_POS = '0,
  localparam int             LEN_W    = $clog2(MAX_LEN) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             move,
  input  logic [POS_W-1:0] new_head,
  input  logic             grow,
  input  logic             render_start,
  input  logic             clear_hit,
  output logic             busy,
  output logic             render_valid,
  output logic [POS_W-1:0] render_pos,
  output logic             render_done,
  output logic [LEN_W-1:0] size,
  output logic             full,
  output logic             self_hit
);

  localparam int PTR_W = $clog2(MAX_LEN);

  typedef enum logic [1:0] {IDLE, RENDER, DONE} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   hp_q;
  logic [PTR_W-1:0]   k_q, k_d;
  logic [LEN_W-1:0]   size_q;
  logic [POS_W-1:0]   entry0_q;
  logic [POS_W-1:0]   entry_rest_q [1:MAX_LEN-1];
  logic [POS_W-1:0]   entries [MAX_LEN];
  logic [PTR_W-1:0]   wptr;
  logic [PTR_W-1:0]   rd_idx;
  logic               move_acc;

  assign move_acc = (state_q == IDLE) && move;
  assign wptr     = hp_q + 1'b1;
  assign rd_idx   = hp_q - k_q;

  // NOTE: every variable driven in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    unique case (state_q)
      IDLE: begin
        // A simultaneous move wins; render_start is dropped.
        if (render_start && !move) begin
          state_d = RENDER;
          k_d     = '0;
        end
      end
      RENDER: begin
        if (LEN_W'(k_q) == size_q - LEN_W'(1)) state_d = DONE;
        else                                   k_d     = k_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      hp_q     <= '0;
      k_q      <= '0;
      size_q   <= LEN_W'(1);
      entry0_q <= INIT_POS;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      if (move_acc) begin
        hp_q <= wptr;
        if (wptr == '0) entry0_q <= new_head;
        if (grow && !full) size_q <= size_q + 1'b1;
      end
    end
  end

  // NOTE: only entry 0 is reset; the rest of the buffer is never read outside 0..size-1, so it stays a plain reset-free register file.
  always_ff @(posedge clock) begin
    for (int i = 1; i < MAX_LEN; i++)
      if (move_acc && wptr == PTR_W'(i)) entry_rest_q[i] <= new_head;
  end

  always_comb begin
    entries[0] = entry0_q;
    for (int i = 1; i < MAX_LEN; i++) entries[i] = entry_rest_q[i];
  end

  assign busy         = (state_q == RENDER);
  assign render_valid = busy;
  assign render_done  = (state_q == DONE);
  assign render_pos   = busy ? entries[rd_idx] : '0;
  assign size         = size_q;
  assign full         = (size_q == LEN_W'(MAX_LEN));

`ifdef SGA_SELF_HIT_EN
  logic [LEN_W-1:0] hit_limit;
  logic             hit;
  logic             self_hit_q;

  // Entry i sits (hp - i) steps behind the head; the tail is excluded when it is about to be dropped.
  always_comb begin
    hit_limit = (grow && !full) ? size_q : size_q - LEN_W'(1);
    hit       = 1'b0;
    for (int i = 0; i < MAX_LEN; i++)
      if ((LEN_W'(PTR_W'(hp_q - PTR_W'(i))) < hit_limit) && (entries[i] == new_head))
        hit = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                self_hit_q <= 1'b0;
    else if (move_acc && hit) self_hit_q <= 1'b1;
    else if (clear_hit)       self_hit_q <= 1'b0;
  end

  assign self_hit = self_hit_q;
`else
  logic unused_clear_hit;
  assign unused_clear_hit = clear_hit;
  assign self_hit         = 1'b0;
`endif

endmodule
